// File: rtl/pwm_peripheral.sv
// Sixteen-pin PWM output stage: each pin is forced low, held high, or follows one shared
// prescaled 8-bit PWM waveform. Define PWM_SHADOW_EN to latch the duty at each period start.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      out_q, out_d;
    logic             period_start_q, period_start_d;
    logic             tick_s;
    logic             wrap_s;
    logic             pwm_sig_s;
    logic [7:0]       duty_active_s;
    logic [15:0]      en_out_s;
    logic [15:0]      en_pwm_s;

    assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_q, duty_d;
    assign duty_active_s = duty_q;
`else
    assign duty_active_s = pwm_duty_cycle;
`endif

    // Next-state logic for the counters, waveform and pin drive.
    always_comb begin
        tick_s = (prescaler_q == PRE_MAX);
        if (tick_s) begin
            prescaler_d = {PRE_W{1'b0}};
            pwm_cnt_d   = pwm_cnt_q + 8'd1;
        end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
            pwm_cnt_d   = pwm_cnt_q;
        end

        wrap_s         = tick_s & (pwm_cnt_q == 8'hFF);
        period_start_d = wrap_s;

        // 0xFF is promoted to a true 100 % duty; the compare alone would top out at 255/256.
        if (duty_active_s == 8'hFF) begin
            pwm_sig_s = 1'b1;
        end else begin
            pwm_sig_s = (pwm_cnt_q < duty_active_s);
        end

        out_d = en_out_s & (~en_pwm_s | {16{pwm_sig_s}});

`ifdef PWM_SHADOW_EN
        if (wrap_s) begin
            duty_d = pwm_duty_cycle;
        end else begin
            duty_d = duty_q;
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q    <= {PRE_W{1'b0}};
            pwm_cnt_q      <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
`ifdef PWM_SHADOW_EN
            duty_q         <= 8'h00;
`endif
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
`ifdef PWM_SHADOW_EN
            duty_q         <= duty_d;
`endif
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral (CLK_DIV=13, period 3328 clk); expectations follow
// PWM_SHADOW_EN when that macro is defined for the build.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = 8'h00;
    logic [7:0]  en_reg_out_15_8 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0 = 8'h00;
    logic [7:0]  en_reg_pwm_15_8 = 8'h00;
    logic [7:0]  pwm_duty_cycle = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int errors = 0;
    int checks = 0;

    pwm_peripheral #(.CLK_DIV(13)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [15:0] en_out, input logic [15:0] en_pwm);
        {en_reg_out_15_8, en_reg_out_7_0} = en_out;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = en_pwm;
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step until period_start is seen, with a cycle budget.
    task automatic wait_ps(input string tag);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < 4000) begin
            step();
            n++;
            if (period_start === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=no period_start in %0d clk expected=period_start", tag, n);
        end
    endtask

    // Step n cycles; out must equal hi_val for steps 1..hi_until and lo_val afterwards.
    // If ps_at > 0, period_start must be high exactly at step ps_at.
    task automatic window(input int n, input int hi_until, input logic [15:0] hi_val,
                          input logic [15:0] lo_val, input int ps_at, input string tag);
        int bad_out = 0;
        int bad_ps = 0;
        int first_i = 0;
        logic [15:0] exp_v;
        logic [15:0] f_obs = 16'h0000;
        logic [15:0] f_exp = 16'h0000;
        for (int i = 1; i <= n; i++) begin
            step();
            exp_v = (i <= hi_until) ? hi_val : lo_val;
            if (out !== exp_v) begin
                if (bad_out == 0) begin
                    f_obs = out;
                    f_exp = exp_v;
                    first_i = i;
                end
                bad_out++;
            end
            if (ps_at > 0 && period_start !== ((i == ps_at) ? 1'b1 : 1'b0)) bad_ps++;
        end
        checks++;
        assert (bad_out === 0) else begin
            errors++;
            $error("FAIL %s_out: %0d bad cycles, first at step %0d observed=%h expected=%h",
                   tag, bad_out, first_i, f_obs, f_exp);
        end
        if (ps_at > 0) begin
            checks++;
            assert (bad_ps === 0) else begin
                errors++;
                $error("FAIL %s_ps: observed=%0d wrong period_start cycles expected=0", tag, bad_ps);
            end
        end
    endtask

    initial begin
        // T1: reset with everything enabled
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        repeat (3) step();
        check_val("t1_out_in_reset", out, 16'h0000);
        check_val("t1_ps_in_reset", {15'h0000, period_start}, 16'h0000);
        rst_n = 1'b1;
        step();
`ifdef PWM_SHADOW_EN
        check_val("t1_first_cycle", out, 16'h0000);
`else
        check_val("t1_first_cycle", out, 16'hFFFF);
`endif

        // T2: static high on pins 7:0, one clk latency, then held
        set_en(16'h00FF, 16'h0000);
        step();
        check_val("t2_latency", out, 16'h00FF);
        window(PERIOD, PERIOD, 16'h00FF, 16'h00FF, 0, "t2_hold");

        // T3: 50 % duty on every pin
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        wait_ps("t3_sync");
        check_val("t3_low_at_ps", out, 16'h0000);
        window(PERIOD, 1664, 16'hFFFF, 16'h0000, PERIOD, "t3_wave");

        // T4: duty extremes, pins 15:8 static, pins 7:0 PWM
        set_en(16'hFFFF, 16'h00FF);
        pwm_duty_cycle = 8'h00;
        wait_ps("t4_sync0");
        window(PERIOD, 0, 16'hFFFF, 16'hFF00, PERIOD, "t4_duty00_a");
        window(PERIOD, 0, 16'hFFFF, 16'hFF00, PERIOD, "t4_duty00_b");
        pwm_duty_cycle = 8'hFF;
        wait_ps("t4_syncff");
        window(PERIOD, PERIOD, 16'hFFFF, 16'h0000, PERIOD, "t4_dutyff_a");
        window(PERIOD, PERIOD, 16'hFFFF, 16'h0000, PERIOD, "t4_dutyff_b");

        // T5: duty 0x40 -> 0xC0 written at pwm_cnt 0x80
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        wait_ps("t5_sync");
        window(1664, 832, 16'hFFFF, 16'h0000, 0, "t5_before");
        pwm_duty_cycle = 8'hC0;
`ifdef PWM_SHADOW_EN
        window(1664, 0, 16'hFFFF, 16'h0000, 1664, "t5_current");
`else
        window(1664, 832, 16'hFFFF, 16'h0000, 1664, "t5_current");
`endif
        window(PERIOD, 2496, 16'hFFFF, 16'h0000, PERIOD, "t5_next");

        // T6: reset at pwm_cnt 0x50
        pwm_duty_cycle = 8'h80;
        wait_ps("t6_sync");
        window(1040, 1040, 16'hFFFF, 16'hFFFF, 0, "t6_pre");
        rst_n = 1'b0;
        #1;
        check_val("t6_async_out", out, 16'h0000);
        check_val("t6_async_ps", {15'h0000, period_start}, 16'h0000);
        repeat (3) step();
        rst_n = 1'b1;
`ifdef PWM_SHADOW_EN
        window(PERIOD, 0, 16'hFFFF, 16'h0000, PERIOD, "t6_post");
`else
        window(PERIOD, 1664, 16'hFFFF, 16'h0000, PERIOD, "t6_post");
`endif
        window(PERIOD, 1664, 16'hFFFF, 16'h0000, PERIOD, "t6_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
